limber_gnrl_ramdp_pipe: RTL
===========================

Name: limber_gnrl_ramdp_pipe

Overview:
Parametrised simple dual-port RAM (one write port, one read port), the successor to the team's basic dual-port RAM. Adds per-lane write mask, configurable read latency with a valid pipeline, and synchronous reset. A post-reset clear sequencer zero-fills the array, so no X ever reaches a read. Used as the generic storage primitive under FIFOs, register files and buffers in the Limber MCU.

Parameters:
DP, 16, number of words (>=2, need not be a power of two)
DW, 32, data width in bits
MW, 4, number of write-mask lanes; DW % MW == 0; lane width LW = DW/MW
AW, 4, address width; $clog2(DP) <= AW
DLY, 1, read latency in clk cycles (>=1)
INIT_CLR, 1, 1 = zero-fill the array after reset; 0 = ready immediately after reset, contents undefined

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
init_busy  out  1  high while the clear sequencer runs; both ports blocked
wr_en  in  1  write request
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_mask  in  MW  lane enables; lane i covers wr_data[i*LW +: LW]
wr_ready  out  1  write accepted this cycle when wr_en & wr_ready
rd_en  in  1  read request
rd_addr  in  AW  read address
rd_ready  out  1  read accepted this cycle when rd_en & rd_ready
rd_valid  out  1  rd_data valid this cycle
rd_data  out  DW  read data

Behaviour:
- Reset (rst high at a clk edge): init_busy=INIT_CLR, wr_ready=rd_ready=!INIT_CLR, rd_valid=0, rd_data=0, valid pipeline cleared, clear pointer=0. Reset mid-operation aborts in-flight reads (no rd_valid) and restarts the clear.
- FSM states: IDLE, CLEAR.
  - From reset: CLEAR if INIT_CLR, else IDLE.
  - CLEAR: writes 0 to address ptr each cycle, ptr++. Leaves for IDLE on the cycle that writes DP-1, so CLEAR lasts exactly DP cycles. init_busy deasserts the cycle after.
  - IDLE: terminal until the next rst.
- wr_ready = rd_ready = (state==IDLE). Requests while not ready are ignored, not queued.
- Write: accepted write updates the masked lanes of mem[wr_addr] at the edge; unmasked lanes are unchanged. wr_mask=0 is a no-op.
- Read: an accepted read samples mem[rd_addr] at the edge. rd_valid and rd_data appear exactly DLY cycles later. Fully pipelined: one read per cycle. No backpressure.
- rd_data holds its last valid value while rd_valid=0; it is 0 after reset.
- Out-of-range address (>= DP): writes are dropped; reads return 0 with rd_valid asserted normally.
- Same-address read and write in the same cycle: the read returns the pre-write contents (read-first), unless the optional feature is enabled.
- Simultaneous read and write to different addresses are independent.

Optional Feature:
LIMBER_RAMDP_WR_BYPASS_EN
- Defined: on a same-address collision, the read returns the merged word: written lanes from wr_data, unwritten lanes from the old contents (write-first). Forwarding happens at the sample stage, so latency is still DLY.
- Undefined: read-first as above, and no bypass logic is generated.

Decomposition:
- Package limber_gnrl_pkg:
  - ramdp_state_e enum (IDLE, CLEAR)
  - function lane_merge(old, new, mask, MW)
  - constant RAMDP_MAX_DLY=8, for parameter checks
- One sub-module: limber_gnrl_vpipe, a DLY-stage valid+data shift pipeline with synchronous reset on the valid bits. It is reusable by other latency-configurable blocks.
- Elaboration-time checks: DW%MW==0, DLY>=1, DP<=2**AW.

Test Plan:
- Clear sequence, DP=16, INIT_CLR=1:
  - release rst -> init_busy high for exactly 16 cycles, wr_ready rises on cycle 17.
  - a read of every address returns 0x00000000.
- Masked write, DLY=2:
  - write 0xAABBCCDD to addr 3 with mask 4'b1111, then 0x11223344 with mask 4'b0101.
  - read addr 3 -> rd_data=0xAA22CC44, rd_valid exactly 2 cycles after acceptance.
- Back-to-back reads, DLY=3: reads of addrs 0..7 on 8 consecutive cycles -> 8 consecutive rd_valid pulses, data in order.
- Collision: addr 5 holds 0x0, then write 0xFFFFFFFF with mask 4'b0011 while reading addr 5 in the same cycle -> 0x00000000 without the macro, 0x0000FFFF with LIMBER_RAMDP_WR_BYPASS_EN.
- Reset mid-operation:
  - assert rst one cycle after a read with DLY=2 -> no rd_valid for that read, rd_data=0, clear restarts.
  - a request issued during CLEAR is ignored: the target word still reads 0 afterwards.
- Out of range, DP=12, AW=4: write 0x12345678 to addr 13, then read addr 13 -> rd_valid with 0; addrs 0..11 are unchanged.

Source files
------------

// File: rtl/limber_gnrl_pkg.sv
// +-----------------------------------------------------------------------------+
// | limber_gnrl_pkg : shared types, limits and helpers for Limber generic RAMs. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package limber_gnrl_pkg;

  localparam int RAMDP_MAX_DLY = 8;
  localparam int RAMDP_MAX_DW  = 256;
  localparam int RAMDP_MAX_MW  = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ramdp_state_e;

  // Lane-masked merge on max-width vectors; callers size-cast in and out.
  function automatic logic [RAMDP_MAX_DW-1:0] lane_merge(
    input logic [RAMDP_MAX_DW-1:0] old_w,
    input logic [RAMDP_MAX_DW-1:0] new_w,
    input logic [RAMDP_MAX_MW-1:0] mask,
    input int                      mw,
    input int                      dw
  );
    logic [RAMDP_MAX_DW-1:0] res;
    int lw;
    lw  = dw / mw;
    res = old_w;
    for (int b = 0; b < RAMDP_MAX_DW; b++) begin
      if (b < dw) begin
        if (mask[b / lw]) res[b] = new_w[b];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/limber_gnrl_vpipe.sv
// +-----------------------------------------------------------------------------+
// | limber_gnrl_vpipe : DLY-stage valid+data shift pipeline; data held when idle.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module limber_gnrl_vpipe #(
  parameter int DLY = 1,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);

  logic [DLY-1:0] vld_q;
  logic [DW-1:0]  dat_q [DLY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DLY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int i = 1; i < DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DLY-1];
  assign dat_o = dat_q[DLY-1];

endmodule

`default_nettype wire

// File: rtl/limber_gnrl_ramdp_pipe.sv
// +-----------------------------------------------------------------------------+
// | limber_gnrl_ramdp_pipe : 1W/1R RAM, lane mask, DLY read pipe, zero-fill.    |
// | Option LIMBER_RAMDP_WR_BYPASS_EN: write-first forwarding on collisions.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module limber_gnrl_ramdp_pipe
  import limber_gnrl_pkg::*;
#(
  parameter int DP       = 16,
  parameter int DW       = 32,
  parameter int MW       = 4,
  parameter int AW       = 4,
  parameter int DLY      = 1,
  parameter int INIT_CLR = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [MW-1:0] wr_mask,
  output logic          wr_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data
);

  localparam int            IW     = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [AW:0]   DP_L   = (AW+1)'(DP);
  localparam logic [IW-1:0] LAST_L = IW'(DP - 1);

  if (DW % MW != 0) begin : g_chk_mw
    $error("DW must be a multiple of MW");
  end
  if (DLY < 1 || DLY > RAMDP_MAX_DLY) begin : g_chk_dly
    $error("DLY out of range");
  end
  if (DP < 2 || DP > (1 << AW)) begin : g_chk_dp
    $error("DP must be >= 2 and fit in AW address bits");
  end
  if (DW > RAMDP_MAX_DW || MW > RAMDP_MAX_MW) begin : g_chk_width
    $error("DW or MW exceeds package limits");
  end

  ramdp_state_e  state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLR != 0) ? CLEAR : IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_L) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == CLEAR);
  assign wr_ready  = (state_q == IDLE);
  assign rd_ready  = (state_q == IDLE);

  logic wr_acc, rd_acc, wr_inr, rd_inr;
  assign wr_acc = wr_en & wr_ready;
  assign rd_acc = rd_en & rd_ready;
  assign wr_inr = ({1'b0, wr_addr} < DP_L);
  assign rd_inr = ({1'b0, rd_addr} < DP_L);

  // Single physical write port, shared between the clear sequencer and users.
  logic          mem_we;
  logic [IW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [MW-1:0] mem_wm;

  always_comb begin
    mem_we = wr_acc & wr_inr;
    mem_wa = wr_addr[IW-1:0];
    mem_wd = wr_data;
    mem_wm = wr_mask;
    if (init_busy) begin
      mem_we = 1'b1;
      mem_wa = ptr_q;
      mem_wd = '0;
      mem_wm = '1;
    end
  end

  logic [DW-1:0] mem_q [DP];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= DW'(lane_merge(RAMDP_MAX_DW'(mem_q[mem_wa]), RAMDP_MAX_DW'(mem_wd),
                                      RAMDP_MAX_MW'(mem_wm), MW, DW));
    end
  end

  logic [DW-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_inr) rd_word = mem_q[rd_addr[IW-1:0]];
`ifdef LIMBER_RAMDP_WR_BYPASS_EN
    if (wr_acc && rd_inr && (wr_addr == rd_addr)) begin
      rd_word = DW'(lane_merge(RAMDP_MAX_DW'(rd_word), RAMDP_MAX_DW'(wr_data),
                               RAMDP_MAX_MW'(wr_mask), MW, DW));
    end
`endif
  end

  limber_gnrl_vpipe #(
    .DLY (DLY),
    .DW  (DW)
  ) u_vpipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_acc),
    .dat_i (rd_word),
    .vld_o (rd_valid),
    .dat_o (rd_data)
  );

endmodule

`default_nettype wire
